arbitro_rr_mux: RTL and testbench

// - Round-robin arbiter sharing the 32-bit 4:1 data MUX (Dado1..Dado4 -> DadoSaida) among four requesters.
// - Drives the MUX Selecao input and returns a one-hot grant to the requesters.
// - Holds a grant for a multi-cycle transaction, bounded by a maximum-ownership timeout.
// - Sits between the requesting units and the MUX select line.

---
 rtl/arbitro_rr_mux_pkg.sv | 16 +
 rtl/arbitro_rr_mux_chk.sv | 22 ++
 rtl/arbitro_rr_mux_seletor_rr.sv | 28 ++
 rtl/arbitro_rr_mux.sv | 103 ++++++++++
 tb/tb_arbitro_rr_mux.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_mux_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 4:1 data MUX select.
package arbitro_rr_mux_pkg;

  localparam int N_REQ    = 4;
  localparam int LARG_SEL = $clog2(N_REQ);

  typedef enum logic {
    LIVRE     = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  function automatic logic [N_REQ-1:0] indice_para_onehot(input logic [LARG_SEL-1:0] indice);
    indice_para_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << indice;
  endfunction

endpackage

// File: rtl/arbitro_rr_mux_chk.sv
// Invariants of the arbiter outputs, kept apart from the datapath.
module arbitro_rr_mux_chk
  import arbitro_rr_mux_pkg::*;
(
  input logic                Clock,
  input logic                Reset,
  input logic [N_REQ-1:0]    Concessao,
  input logic [LARG_SEL-1:0] Selecao,
  input logic                Ocupado,
  input logic                Expirado
);

  a_grant_matches_select: assert property (@(posedge Clock) disable iff (Reset)
    Ocupado |-> (Concessao == indice_para_onehot(Selecao)));

  a_idle_no_grant: assert property (@(posedge Clock) disable iff (Reset)
    !Ocupado |-> (Concessao == {N_REQ{1'b0}}));

  a_timeout_only_when_free: assert property (@(posedge Clock) disable iff (Reset)
    Expirado |-> !Ocupado);

endmodule

// File: rtl/arbitro_rr_mux_seletor_rr.sv
// Rotate-priority pick: the first active request found scanning from ptr upward (mod N_REQ) wins.
module seletor_rr
  import arbitro_rr_mux_pkg::*;
(
  input  logic [N_REQ-1:0]    requisicao,
  input  logic [LARG_SEL-1:0] ptr,
  output logic                valido,
  output logic [LARG_SEL-1:0] vencedor
);

  logic [LARG_SEL-1:0] candidato_s;
  logic                acerto_s;

  // Walk the requesters in priority order, latching only the first hit.
  always_comb begin
    valido      = 1'b0;
    vencedor    = ptr;
    candidato_s = ptr;
    acerto_s    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      candidato_s = ptr + LARG_SEL'(k);
      acerto_s    = requisicao[candidato_s] & ~valido;
      vencedor    = acerto_s ? candidato_s : vencedor;
      valido      = valido | requisicao[candidato_s];
    end
  end

endmodule

// File: rtl/arbitro_rr_mux.sv
// Round-robin owner of the shared 4:1 MUX: grants one requester at a time for a bounded
// transaction and drives the MUX select with the holder's index.
module arbitro_rr_mux
  import arbitro_rr_mux_pkg::*;
#(
  parameter int MAX_POSSE = 16,
  parameter int LARG_CONT = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [N_REQ-1:0]    Requisicao,
  input  logic [N_REQ-1:0]    Liberacao,
  output logic [N_REQ-1:0]    Concessao,
  output logic [LARG_SEL-1:0] Selecao,
  output logic                Ocupado,
  output logic                Expirado
);

  localparam logic [LARG_CONT-1:0] LIM_CONT = LARG_CONT'(MAX_POSSE - 1);

  estado_t             estado_r;
  logic [LARG_SEL-1:0] ptr_r;
  logic [LARG_CONT-1:0] contador_r;

  logic                valido_s;
  logic [LARG_SEL-1:0] vencedor_s;
  logic                pedido_dono_s;
  logic                libera_dono_s;
  logic                limite_s;
  logic                fim_s;
  logic                so_timeout_s;

  seletor_rr u_seletor (
    .requisicao (Requisicao),
    .ptr        (ptr_r),
    .valido     (valido_s),
    .vencedor   (vencedor_s)
  );

  // Selecao doubles as the holder index while a grant is active.
  always_comb begin
    pedido_dono_s = Requisicao[Selecao];
    libera_dono_s = Liberacao[Selecao];
    limite_s      = (contador_r == LIM_CONT);
    fim_s         = libera_dono_s | ~pedido_dono_s | limite_s;
    so_timeout_s  = limite_s & ~libera_dono_s & pedido_dono_s;
  end

  // Arbitration FSM with registered grant, select, busy and timeout outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_r   <= LIVRE;
      ptr_r      <= {LARG_SEL{1'b0}};
      contador_r <= {LARG_CONT{1'b0}};
      Concessao  <= {N_REQ{1'b0}};
      Selecao    <= {LARG_SEL{1'b0}};
      Ocupado    <= 1'b0;
      Expirado   <= 1'b0;
    end else begin
      Expirado <= 1'b0;
      case (estado_r)
        LIVRE: begin
          if (valido_s) begin
            Concessao  <= indice_para_onehot(vencedor_s);
            Selecao    <= vencedor_s;
            Ocupado    <= 1'b1;
            contador_r <= {LARG_CONT{1'b0}};
            estado_r   <= CONCEDIDO;
          end else begin
            estado_r <= LIVRE;
          end
        end
        CONCEDIDO: begin
          if (fim_s) begin
            // Select stays put so the MUX output remains stable while idle.
            Concessao <= {N_REQ{1'b0}};
            Ocupado   <= 1'b0;
            Expirado  <= so_timeout_s;
            ptr_r     <= Selecao + LARG_SEL'(1);
            estado_r  <= LIVRE;
          end else begin
            contador_r <= contador_r + LARG_CONT'(1);
          end
        end
        default: begin
          estado_r  <= LIVRE;
          Concessao <= {N_REQ{1'b0}};
          Ocupado   <= 1'b0;
        end
      endcase
    end
  end

  arbitro_rr_mux_chk u_chk (
    .Clock     (Clock),
    .Reset     (Reset),
    .Concessao (Concessao),
    .Selecao   (Selecao),
    .Ocupado   (Ocupado),
    .Expirado  (Expirado)
  );

endmodule

// File: tb/tb_arbitro_rr_mux.sv
// Directed scenarios plus random traffic for arbitro_rr_mux, checked against a cycle-level model.
module tb_arbitro_rr_mux;

  localparam int MAXP = 16;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Requisicao;
  logic [3:0] Liberacao;
  logic [3:0] Concessao;
  logic [1:0] Selecao;
  logic       Ocupado;
  logic       Expirado;

  logic [31:0] dado [4];
  logic [31:0] saida_mux;
  assign saida_mux = dado[Selecao];

  int erros  = 0;
  int checks = 0;

  // Model: owner index (-1 = none), next-priority index, cycles owned so far.
  int m_dono  = -1;
  int m_rr    = 0;
  int m_posse = 0;
  int m_sel   = 0;
  bit m_expir = 1'b0;

  int         ordem[$];
  int         bolhas[$];
  int         esp_ordem[5];
  int         ocioso;
  int         posse;
  int         n_posse;
  logic [3:0] anterior;

  arbitro_rr_mux #(.MAX_POSSE(MAXP), .LARG_CONT(5)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Requisicao (Requisicao),
    .Liberacao  (Liberacao),
    .Concessao  (Concessao),
    .Selecao    (Selecao),
    .Ocupado    (Ocupado),
    .Expirado   (Expirado)
  );

  always #5 Clock = ~Clock;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      erros++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic modelo_passo();
    if (Reset) begin
      m_dono = -1; m_rr = 0; m_posse = 0; m_sel = 0; m_expir = 1'b0;
    end else if (m_dono < 0) begin
      m_expir = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (m_dono < 0 && Requisicao[c]) begin
          m_dono = c; m_sel = c; m_posse = 1;
        end
      end
    end else begin
      m_expir = 1'b0;
      if (Liberacao[m_dono] || !Requisicao[m_dono] || m_posse == MAXP) begin
        m_expir = (m_posse == MAXP) && !Liberacao[m_dono] && Requisicao[m_dono];
        m_rr    = (m_dono + 1) % 4;
        m_dono  = -1;
      end else begin
        m_posse++;
      end
    end
  endtask

  task automatic ciclo();
    @(posedge Clock);
    modelo_passo();
    #1;
    verifica("model_conc", 32'(Concessao), (m_dono < 0) ? 32'd0 : (32'd1 << m_dono));
    verifica("model_sel",  32'(Selecao),   32'(m_sel));
    verifica("model_ocup", 32'(Ocupado),   32'(m_dono >= 0));
    verifica("model_exp",  32'(Expirado),  32'(m_expir));
  endtask

  task automatic reinicia();
    Requisicao = 4'b0000;
    Liberacao  = 4'b0000;
    Reset      = 1'b1;
    ciclo();
    Reset      = 1'b0;
  endtask

  initial begin
    dado[0] = 32'h1111_0001; dado[1] = 32'h2222_0002;
    dado[2] = 32'h3333_0003; dado[3] = 32'h4444_0004;
    esp_ordem = '{1, 2, 4, 8, 1};
    Requisicao = 4'b0000;
    Liberacao  = 4'b0000;
    Reset      = 1'b1;
    ciclo();
    ciclo();
    verifica("reset_conc", 32'(Concessao), 32'h0);
    verifica("reset_sel",  32'(Selecao),   32'h0);
    verifica("reset_ocup", 32'(Ocupado),   32'h0);
    verifica("reset_exp",  32'(Expirado),  32'h0);
    Reset = 1'b0;

    // Single request from requester 2.
    Requisicao = 4'b0100;
    ciclo();
    verifica("t1_conc", 32'(Concessao), 32'h4);
    verifica("t1_sel",  32'(Selecao),   32'h2);
    verifica("t1_ocup", 32'(Ocupado),   32'h1);
    verifica("t1_mux",  saida_mux,      dado[2]);

    // Everyone requesting, each holder releases 2 cycles into its grant.
    reinicia();
    Requisicao = 4'b1111;
    ocioso = 0; posse = 0; anterior = 4'b0000;
    for (int i = 0; i < 40 && ordem.size() < 5; i++) begin
      ciclo();
      if (Concessao != 4'b0000) begin
        if (anterior == 4'b0000) begin
          ordem.push_back(int'(Concessao));
          bolhas.push_back(ocioso);
          posse = 0;
        end else begin
          posse++;
        end
        ocioso    = 0;
        Liberacao = (posse == 2) ? Concessao : 4'b0000;
      end else begin
        ocioso++;
        Liberacao = 4'b0000;
      end
      anterior = Concessao;
    end
    verifica("t2_grants", 32'(ordem.size()), 32'd5);
    for (int j = 0; j < ordem.size(); j++) begin
      verifica("t2_order", 32'(ordem[j]), 32'(esp_ordem[j]));
      if (j > 0) verifica("t2_bubble", 32'(bolhas[j]), 32'd1);
    end

    // Requester 1 never releases; requester 2 waits.
    reinicia();
    Requisicao = 4'b0110;
    ciclo();
    n_posse = 0;
    for (int i = 0; i < 20; i++) begin
      if (Concessao == 4'b0010) begin
        n_posse++;
        ciclo();
      end
    end
    verifica("t3_hold",    32'(n_posse),   32'd16);
    verifica("t3_exp",     32'(Expirado),  32'h1);
    verifica("t3_free",    32'(Concessao), 32'h0);
    ciclo();
    verifica("t3_exp_end", 32'(Expirado),  32'h0);
    verifica("t3_next",    32'(Concessao), 32'h4);

    // Release coincides with the final ownership cycle.
    reinicia();
    Requisicao = 4'b0100;
    ciclo();
    repeat (15) ciclo();
    Liberacao = 4'b0100;
    ciclo();
    verifica("t4_conc", 32'(Concessao), 32'h0);
    verifica("t4_exp",  32'(Expirado),  32'h0);
    Liberacao  = 4'b0000;
    Requisicao = 4'b1111;
    ciclo();
    verifica("t4_ptr",  32'(Concessao), 32'h8);
    verifica("t4_sel",  32'(Selecao),   32'h3);

    // Non-holder releases are ignored; holder dropping its request ends the grant.
    reinicia();
    Requisicao = 4'b0001;
    ciclo();
    Liberacao  = 4'b1110;
    Requisicao = 4'b1111;
    repeat (3) begin
      ciclo();
      verifica("t5_keep", 32'(Concessao), 32'h1);
    end
    Requisicao = 4'b1110;
    ciclo();
    verifica("t5_drop", 32'(Concessao), 32'h0);

    // Reset in the middle of a grant.
    reinicia();
    Requisicao = 4'b1000;
    ciclo();
    repeat (7) ciclo();
    verifica("t6_held", 32'(Concessao), 32'h8);
    Reset = 1'b1;
    ciclo();
    verifica("t6_conc", 32'(Concessao), 32'h0);
    verifica("t6_sel",  32'(Selecao),   32'h0);
    verifica("t6_ocup", 32'(Ocupado),   32'h0);
    verifica("t6_exp",  32'(Expirado),  32'h0);
    Reset      = 1'b0;
    Requisicao = 4'b1001;
    ciclo();
    verifica("t6_first", 32'(Concessao), 32'h1);

    // Random traffic with slowly changing requests.
    reinicia();
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) Requisicao[b] = ~Requisicao[b];
      end
      Liberacao = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      Reset     = ($urandom_range(0, 99) == 0);
      ciclo();
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
